// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared encodings for the load/store unit: mm write-size codes,
//            FSM state codes and a byte-count helper.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // mm write-strobe / access-size encoding
  localparam logic [1:0] MM_WR_NONE = 2'b00;
  localparam logic [1:0] MM_WR_B    = 2'b01;
  localparam logic [1:0] MM_WR_HW   = 2'b10;
  localparam logic [1:0] MM_WR_W    = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_ISSUE   = 2'd1,
    LSU_CAPTURE = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_e;

  // Number of bytes touched by an access of the given size (0 for NONE).
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      MM_WR_B:  size_nbytes = 3'd1;
      MM_WR_HW: size_nbytes = 3'd2;
      MM_WR_W:  size_nbytes = 3'd4;
      default:  size_nbytes = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ext
// Purpose  : Combinational load-data extraction with zero/sign extension of
//            the low byte or halfword of the mm read word.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  // Select the accessed field and fill the upper bits with sign or zero
  always_comb begin
    data_o = data_i;
    case (size_i)
      MM_WR_B:  data_o = {{24{signed_i & data_i[7]}},  data_i[7:0]};
      MM_WR_HW: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default:  data_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit between the CPU datapath and the bit-addressed
//            main memory mm. One request at a time; checks size, range and
//            alignment, sequences mm's write strobe and registered read.
// Revision : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 128,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] BADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic [1:0]  MM_WR,
  output logic [31:0] MM_D_IN_ADDR,
  output logic [31:0] MM_D_OUT_ADDR,
  output logic [31:0] MM_D_IN,
  input  logic [31:0] MM_D_OUT
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  // Only the low 29 address bits survive the byte-to-bit conversion.
  logic [28:0] baddr_q, baddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [32:0] end_addr;
  logic        misaligned;
  logic        req_err;
  logic [31:0] ext_data;

  lsu_ext u_ext (
    .data_i   (MM_D_OUT),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  // Request checks on the incoming (not yet latched) fields; 33-bit sum avoids wrap
  always_comb begin
    end_addr   = {1'b0, BADDR} + {30'd0, size_nbytes(SIZE)};
    misaligned = ((SIZE == MM_WR_HW) && BADDR[0]) ||
                 ((SIZE == MM_WR_W)  && (BADDR[1:0] != 2'b00));
    req_err    = (SIZE == MM_WR_NONE) ||
                 (end_addr > 33'(MEM_BYTES)) ||
                 (ALIGN_CHECK && misaligned);
  end

  // Next-state and latch-update logic
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    baddr_d  = baddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (REQ) begin
          we_d     = WE;
          size_d   = SIZE;
          signed_d = SIGNED;
          baddr_d  = BADDR[28:0];
          wdata_d  = WDATA;
          err_d    = req_err;
          state_d  = req_err ? LSU_RESP : LSU_ISSUE;
        end
      end
      LSU_ISSUE:   state_d = we_q ? LSU_RESP : LSU_CAPTURE;
      LSU_CAPTURE: begin
        rdata_d = ext_data;
        state_d = LSU_RESP;
      end
      LSU_RESP:    state_d = LSU_IDLE;
      default:     state_d = LSU_IDLE;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      size_q   <= MM_WR_NONE;
      signed_q <= 1'b0;
      baddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      baddr_q  <= baddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs; the write strobe is gated by RST so an aborted store never lands
  always_comb begin
    BUSY          = (state_q != LSU_IDLE);
    DONE          = (state_q == LSU_RESP);
    ERR           = DONE & err_q;
    RDATA         = rdata_q;
    MM_D_IN_ADDR  = {baddr_q, 3'b000};
    MM_D_OUT_ADDR = {baddr_q, 3'b000};
    MM_D_IN       = wdata_q;
    MM_WR         = (state_q == LSU_ISSUE && we_q && !RST) ? size_q : MM_WR_NONE;
  end

endmodule
`default_nettype wire
